// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares one 8-bit SDRAM controller between video fetch (read-only), CPU
// (read/write) and download (write-only). One memory slot per clkref period.
// The slot winner is registered onto mem_* at the closing edge of ARB_PHASE.
// The winner's ack pulses, and read data is captured, at the closing edge of
// DONE_PHASE that follows.
module sdram_arbiter #(
   parameter int ARB_PHASE  = 7,
   parameter int DONE_PHASE = 6,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clkref,
   input  logic        vid_req,
   input  logic [24:0] vid_addr,
   output logic        vid_ack,
   output logic [7:0]  vid_dout,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [24:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   output logic        cpu_ack,
   output logic [7:0]  cpu_dout,
   input  logic        dl_req,
   input  logic [24:0] dl_addr,
   input  logic [7:0]  dl_din,
   output logic        dl_ack,
   output logic [24:0] mem_addr,
   output logic [7:0]  mem_din,
   output logic        mem_oe,
   output logic        mem_we,
   input  logic [7:0]  mem_dout
);

   localparam int NPORT = 3;
   localparam logic [1:0] PORT_VID = 2'd0;
   localparam logic [1:0] PORT_CPU = 2'd1;
   localparam logic [1:0] PORT_DL  = 2'd2;
   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [2:0] ARB_PH  = 3'(ARB_PHASE);
   localparam logic [2:0] DONE_PH = 3'(DONE_PHASE);

   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_VID  = 2'd1,
      GRANT_CPU  = 2'd2,
      GRANT_DL   = 2'd3
   } grant_t;

   // phase tracking
   logic        clkref_d_reg;
   logic [2:0]  ph_reg, ph_next;
   logic        ref_edge, arb_edge, done_edge;

   // slot ownership and controller-side registers
   grant_t      grant_reg, grant_next;
   logic [24:0] mem_addr_reg, mem_addr_next;
   logic [7:0]  mem_din_reg, mem_din_next;
   logic        mem_oe_reg, mem_oe_next;
   logic        mem_we_reg, mem_we_next;

   // requester-side registers
   logic        vid_ack_reg, vid_ack_next;
   logic        cpu_ack_reg, cpu_ack_next;
   logic        dl_ack_reg, dl_ack_next;
   logic [7:0]  vid_dout_reg, vid_dout_next;
   logic [7:0]  cpu_dout_reg, cpu_dout_next;

   // starvation counters: index 0 = cpu, index 1 = dl
   logic [SW-1:0] starve_reg [2];
   logic [SW-1:0] starve_next [2];

   // per-port views so arbitration can be written once for all ports
   logic [NPORT-1:0] port_req;
   logic [NPORT-1:0] port_ack;
   logic [NPORT-1:0] port_wr;
   logic [NPORT-1:0] eligible;
   logic [24:0]      port_addr [NPORT];
   logic [7:0]       port_din  [NPORT];

   logic       win_valid;
   logic [1:0] win_idx;
   grant_t     win_grant;

   assign port_req = {dl_req, cpu_req, vid_req};
   assign port_ack = {dl_ack_reg, cpu_ack_reg, vid_ack_reg};
   assign port_wr  = {1'b1, cpu_we, 1'b0};

   assign port_addr[PORT_VID] = vid_addr;
   assign port_addr[PORT_CPU] = cpu_addr;
   assign port_addr[PORT_DL]  = dl_addr;
   assign port_din[PORT_VID]  = 8'h00;
   assign port_din[PORT_CPU]  = cpu_din;
   assign port_din[PORT_DL]   = dl_din;

   assign ref_edge  = clkref & ~clkref_d_reg;
   assign ph_next   = ref_edge ? 3'd0 : ph_reg + 3'd1;
   assign arb_edge  = (ph_reg == ARB_PH);
   assign done_edge = (ph_reg == DONE_PH);

   // A port whose ack is high this clock has just been served; its req may
   // still be high from the old request, so it must sit this slot out.
   genvar gi;
   generate
      for (gi = 0; gi < NPORT; gi++) begin : g_elig
         assign eligible[gi] = port_req[gi] & ~port_ack[gi];
      end
   endgenerate

   // Winner selection: a starved cpu, then a starved dl, then vid > cpu > dl.
   always_comb begin
      win_valid = 1'b1;
      win_idx   = PORT_VID;
      if (eligible[PORT_CPU] && starve_reg[0] == STARVE_LIM)
         win_idx = PORT_CPU;
      else if (eligible[PORT_DL] && starve_reg[1] == STARVE_LIM)
         win_idx = PORT_DL;
      else if (eligible[PORT_VID])
         win_idx = PORT_VID;
      else if (eligible[PORT_CPU])
         win_idx = PORT_CPU;
      else if (eligible[PORT_DL])
         win_idx = PORT_DL;
      else
         win_valid = 1'b0;
   end

   assign win_grant = win_valid ? grant_t'(win_idx + 2'd1) : GRANT_NONE;

   // Starve counters clear when served or idle, and count eligible losses up to the limit.
   generate
      for (gi = 0; gi < 2; gi++) begin : g_starve
         logic clear_cnt, inc_cnt;
         assign clear_cnt = ~port_req[gi + 1] | (win_valid & (win_idx == 2'(gi + 1)));
         assign inc_cnt   = eligible[gi + 1] & (starve_reg[gi] != STARVE_LIM);
         assign starve_next[gi] = !arb_edge ? starve_reg[gi] :
                                  clear_cnt ? '0 :
                                  inc_cnt   ? starve_reg[gi] + 1'b1 :
                                              starve_reg[gi];
      end
   endgenerate

   // Slot sequencing: complete the running access at DONE, pick the next owner at ARB.
   always_comb begin
      grant_next    = grant_reg;
      mem_addr_next = mem_addr_reg;
      mem_din_next  = mem_din_reg;
      mem_oe_next   = mem_oe_reg;
      mem_we_next   = mem_we_reg;
      vid_ack_next  = 1'b0;
      cpu_ack_next  = 1'b0;
      dl_ack_next   = 1'b0;
      vid_dout_next = vid_dout_reg;
      cpu_dout_next = cpu_dout_reg;

      if (done_edge && grant_reg != GRANT_NONE) begin
         case (grant_reg)
            GRANT_VID: begin
               vid_ack_next  = 1'b1;
               vid_dout_next = mem_dout;
            end
            GRANT_CPU: begin
               cpu_ack_next = 1'b1;
               // a cpu write leaves the last read data in place
               if (mem_oe_reg)
                  cpu_dout_next = mem_dout;
            end
            GRANT_DL: begin
               dl_ack_next = 1'b1;
            end
            default: begin
            end
         endcase
         grant_next = GRANT_NONE;
      end

      if (arb_edge) begin
         if (win_valid) begin
            grant_next    = win_grant;
            mem_addr_next = port_addr[win_idx];
            // video has no write data; leave the bus value alone
            if (win_idx != PORT_VID)
               mem_din_next = port_din[win_idx];
            mem_we_next   = port_wr[win_idx];
            mem_oe_next   = ~port_wr[win_idx];
         end else begin
            // idle slot: controller is free to refresh
            grant_next  = GRANT_NONE;
            mem_oe_next = 1'b0;
            mem_we_next = 1'b0;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         clkref_d_reg <= 1'b0;
         ph_reg       <= 3'd0;
         grant_reg    <= GRANT_NONE;
         mem_addr_reg <= '0;
         mem_din_reg  <= '0;
         mem_oe_reg   <= 1'b0;
         mem_we_reg   <= 1'b0;
         vid_ack_reg  <= 1'b0;
         cpu_ack_reg  <= 1'b0;
         dl_ack_reg   <= 1'b0;
         vid_dout_reg <= '0;
         cpu_dout_reg <= '0;
         starve_reg[0] <= '0;
         starve_reg[1] <= '0;
      end else begin
         clkref_d_reg <= clkref;
         ph_reg       <= ph_next;
         grant_reg    <= grant_next;
         mem_addr_reg <= mem_addr_next;
         mem_din_reg  <= mem_din_next;
         mem_oe_reg   <= mem_oe_next;
         mem_we_reg   <= mem_we_next;
         vid_ack_reg  <= vid_ack_next;
         cpu_ack_reg  <= cpu_ack_next;
         dl_ack_reg   <= dl_ack_next;
         vid_dout_reg <= vid_dout_next;
         cpu_dout_reg <= cpu_dout_next;
         starve_reg[0] <= starve_next[0];
         starve_reg[1] <= starve_next[1];
      end
   end

   assign mem_addr = mem_addr_reg;
   assign mem_din  = mem_din_reg;
   assign mem_oe   = mem_oe_reg;
   assign mem_we   = mem_we_reg;
   assign vid_ack  = vid_ack_reg;
   assign cpu_ack  = cpu_ack_reg;
   assign dl_ack   = dl_ack_reg;
   assign vid_dout = vid_dout_reg;
   assign cpu_dout = cpu_dout_reg;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// Random requesters on all three ports plus directed slot scenarios, with a
// behavioural slot model that predicts every output on every clock.
module tb_sdram_arbiter;

   localparam int ARB_PHASE  = 7;
   localparam int DONE_PHASE = 6;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        clkref;
   logic        vid_req, cpu_req, cpu_we, dl_req;
   logic [24:0] vid_addr, cpu_addr, dl_addr;
   logic [7:0]  cpu_din, dl_din, mem_dout;
   logic        vid_ack, cpu_ack, dl_ack;
   logic [7:0]  vid_dout, cpu_dout, mem_din;
   logic [24:0] mem_addr;
   logic        mem_oe, mem_we;

   always #5 clk = ~clk;

   sdram_arbiter #(
      .ARB_PHASE(ARB_PHASE),
      .DONE_PHASE(DONE_PHASE),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk), .reset(reset), .clkref(clkref),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
      .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_oe(mem_oe), .mem_we(mem_we),
      .mem_dout(mem_dout)
   );

   int check_cnt = 0;
   int pass_cnt  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // ---------------- behavioural reference model ----------------
   int          m_ph;
   bit          m_clkref_d;
   int          m_owner;          // -1 when no slot is in flight, else port 0=vid 1=cpu 2=dl
   bit          m_owner_rd;
   int          m_starve [2];     // losses in a row for cpu, dl
   logic [24:0] m_addr;
   logic [7:0]  m_din;
   bit          m_oe, m_we;
   bit          m_ack [3];
   logic [7:0]  m_dout [3];

   function automatic int pick(input bit [2:0] el, input int s_cpu, input int s_dl);
      if (el[1] && s_cpu == STARVE_MAX) return 1;
      if (el[2] && s_dl == STARVE_MAX) return 2;
      for (int i = 0; i < 3; i++)
         if (el[i]) return i;
      return -1;
   endfunction

   task automatic model_step();
      bit          rq [3];
      bit          wr [3];
      logic [24:0] ad [3];
      logic [7:0]  dn [3];
      bit          old_ack [3];
      bit [2:0]    el;
      int          win;
      rq = '{vid_req, cpu_req, dl_req};
      wr = '{1'b0, cpu_we, 1'b1};
      ad = '{vid_addr, cpu_addr, dl_addr};
      dn = '{8'h00, cpu_din, dl_din};
      if (reset) begin
         m_ph = 0; m_clkref_d = 0; m_owner = -1; m_owner_rd = 0;
         m_starve = '{0, 0};
         m_addr = '0; m_din = '0; m_oe = 0; m_we = 0;
         m_ack = '{0, 0, 0};
         m_dout = '{8'h00, 8'h00, 8'h00};
         return;
      end
      old_ack = m_ack;
      m_ack = '{0, 0, 0};
      if (m_ph == DONE_PHASE && m_owner >= 0) begin
         m_ack[m_owner] = 1;
         if (m_owner_rd) m_dout[m_owner] = mem_dout;
         m_owner = -1;
      end
      if (m_ph == ARB_PHASE) begin
         for (int i = 0; i < 3; i++) el[i] = rq[i] && !old_ack[i];
         win = pick(el, m_starve[0], m_starve[1]);
         for (int k = 0; k < 2; k++) begin
            if (!rq[k+1] || win == k + 1) m_starve[k] = 0;
            else if (el[k+1] && m_starve[k] < STARVE_MAX) m_starve[k]++;
         end
         if (win < 0) begin
            m_owner = -1; m_oe = 0; m_we = 0;
         end else begin
            m_owner = win;
            m_owner_rd = !wr[win];
            m_addr = ad[win];
            if (win != 0) m_din = dn[win];
            m_oe = !wr[win];
            m_we = wr[win];
         end
      end
      if (clkref && !m_clkref_d) m_ph = 0;
      else m_ph = (m_ph + 1) % 8;
      m_clkref_d = clkref;
   endtask

   task automatic compare_all();
      check_val("mem_oe", mem_oe, m_oe);
      check_val("mem_we", mem_we, m_we);
      check_val("mem_addr", mem_addr, m_addr);
      check_val("mem_din", mem_din, m_din);
      check_val("vid_ack", vid_ack, m_ack[0]);
      check_val("cpu_ack", cpu_ack, m_ack[1]);
      check_val("dl_ack", dl_ack, m_ack[2]);
      check_val("vid_dout", vid_dout, m_dout[0]);
      check_val("cpu_dout", cpu_dout, m_dout[1]);
   endtask

   // ---------------- clocking of stimulus ----------------
   int cyc = 0;
   bit clkref_run = 1;
   bit dout_fixed = 0;

   // one clock: model follows the edge, outputs compared on the falling edge,
   // then clkref and mem_dout advance for the next edge
   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      cyc++;
      if (clkref_run) clkref = ((cyc % 8) < 4);
      if (!dout_fixed) mem_dout = 8'($urandom);
   endtask

   task automatic agents();
      if (vid_req && vid_ack) begin
         if ($urandom_range(1) == 0) vid_req = 0; else vid_addr = 25'($urandom);
      end else if (!vid_req) begin
         if ($urandom_range(3) == 0) begin vid_req = 1; vid_addr = 25'($urandom); end
      end else if ($urandom_range(63) == 0) vid_req = 0;

      if (cpu_req && cpu_ack) begin
         if ($urandom_range(1) == 0) cpu_req = 0;
         else begin cpu_addr = 25'($urandom); cpu_din = 8'($urandom); cpu_we = 1'($urandom); end
      end else if (!cpu_req) begin
         if ($urandom_range(3) == 0) begin
            cpu_req = 1; cpu_addr = 25'($urandom); cpu_din = 8'($urandom); cpu_we = 1'($urandom);
         end
      end else if ($urandom_range(63) == 0) cpu_req = 0;

      if (dl_req && dl_ack) begin
         if ($urandom_range(1) == 0) dl_req = 0;
         else begin dl_addr = 25'($urandom); dl_din = 8'($urandom); end
      end else if (!dl_req) begin
         if ($urandom_range(3) == 0) begin dl_req = 1; dl_addr = 25'($urandom); dl_din = 8'($urandom); end
      end else if ($urandom_range(63) == 0) dl_req = 0;
   endtask

   task automatic idle_all();
      vid_req = 0; cpu_req = 0; dl_req = 0;
      repeat (20) step();
   endtask

   initial begin
      bit          seen, seen_mem;
      int          n_busy, n_other, lat;
      logic [24:0] cap_addr;
      logic [7:0]  cap_din;
      int          order [3];
      int          when  [3];
      int          n_ack;

      reset = 1; clkref = 0; mem_dout = 0;
      vid_req = 0; cpu_req = 0; dl_req = 0; cpu_we = 0;
      vid_addr = 0; cpu_addr = 0; dl_addr = 0; cpu_din = 0; dl_din = 0;
      repeat (4) step();
      check_val("rst_mem_oe", mem_oe, 0);
      check_val("rst_mem_we", mem_we, 0);
      check_val("rst_mem_addr", mem_addr, 0);
      check_val("rst_mem_din", mem_din, 0);
      check_val("rst_cpu_dout", cpu_dout, 0);
      check_val("rst_acks", {vid_ack, cpu_ack, dl_ack}, 0);
      reset = 0;

      // random traffic
      repeat (2000) begin step(); agents(); end
      // clkref stopped: phase counter free-runs, slots continue
      clkref_run = 0; clkref = 0;
      repeat (60) begin step(); agents(); end
      clkref_run = 1;
      repeat (400) begin step(); agents(); end

      // no requests: every slot idle, no acks
      idle_all();
      n_busy = 0;
      repeat (24) begin
         step();
         if (mem_oe || mem_we || vid_ack || cpu_ack || dl_ack) n_busy++;
      end
      check_val("idle_busy_clks", n_busy, 0);

      // single CPU read
      dout_fixed = 1; mem_dout = 8'h5A;
      cpu_addr = 25'h000123; cpu_we = 0; cpu_din = 8'h00; cpu_req = 1;
      seen = 0; seen_mem = 0; cap_addr = '0; lat = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step(); lat++;
         if (mem_oe && !seen_mem) begin seen_mem = 1; cap_addr = mem_addr; end
         if (cpu_ack) seen = 1;
      end
      cpu_req = 0;
      check_val("rd_ack_seen", seen, 1);
      check_val("rd_oe_seen", seen_mem, 1);
      check_val("rd_addr", cap_addr, 25'h000123);
      check_val("rd_data", cpu_dout, 8'h5A);
      check_val("rd_latency_ok", lat <= 16, 1);

      // CPU write to top of address space; read data must survive
      idle_all();
      mem_dout = 8'h33;
      cpu_addr = 25'h1FFFFFF; cpu_we = 1; cpu_din = 8'hA5; cpu_req = 1;
      seen = 0; seen_mem = 0; cap_addr = '0; cap_din = '0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         if (mem_we && !seen_mem) begin seen_mem = 1; cap_addr = mem_addr; cap_din = mem_din; end
         if (cpu_ack) seen = 1;
      end
      cpu_req = 0; cpu_we = 0;
      check_val("wr_ack_seen", seen, 1);
      check_val("wr_we_seen", seen_mem, 1);
      check_val("wr_addr", cap_addr, 25'h1FFFFFF);
      check_val("wr_din", cap_din, 8'hA5);
      check_val("wr_cpu_dout_kept", cpu_dout, 8'h5A);
      dout_fixed = 0;

      // all three at once: vid, cpu, dl in consecutive slots
      idle_all();
      vid_addr = 25'h10; cpu_addr = 25'h20; cpu_we = 0; dl_addr = 25'h30; dl_din = 8'h77;
      vid_req = 1; cpu_req = 1; dl_req = 1;
      n_ack = 0; order = '{-1, -1, -1}; when = '{0, 0, 0};
      for (int i = 0; i < 60 && n_ack < 3; i++) begin
         step();
         if (vid_ack) begin order[n_ack] = 0; when[n_ack] = i; n_ack++; vid_req = 0; end
         if (cpu_ack && n_ack < 3) begin order[n_ack] = 1; when[n_ack] = i; n_ack++; cpu_req = 0; end
         if (dl_ack && n_ack < 3) begin order[n_ack] = 2; when[n_ack] = i; n_ack++; dl_req = 0; end
      end
      check_val("sim_ack_count", n_ack, 3);
      check_val("sim_first_vid", order[0], 0);
      check_val("sim_second_cpu", order[1], 1);
      check_val("sim_third_dl", order[2], 2);
      check_val("sim_gap1", when[1] - when[0], 8);
      check_val("sim_gap2", when[2] - when[1], 8);

      // vid and cpu keep re-requesting; dl is forced in after STARVE_MAX losses
      idle_all();
      vid_req = 1; cpu_req = 1; cpu_we = 0; dl_req = 1;
      seen = 0; n_other = 0;
      for (int i = 0; i < 120 && !seen; i++) begin
         step();
         if (vid_ack) begin n_other++; vid_addr = 25'($urandom); end
         if (cpu_ack) begin n_other++; cpu_addr = 25'($urandom); end
         if (dl_ack) seen = 1;
      end
      vid_req = 0; cpu_req = 0; dl_req = 0;
      check_val("starve_dl_served", seen, 1);
      check_val("starve_dl_losses", n_other, STARVE_MAX);

      // reset between grant and completion
      idle_all();
      cpu_addr = 25'h0ABCDE; cpu_we = 0; cpu_req = 1;
      seen_mem = 0;
      for (int i = 0; i < 40 && !seen_mem; i++) begin
         step();
         if (mem_oe) seen_mem = 1;
      end
      check_val("rst_mid_granted", seen_mem, 1);
      step();
      reset = 1;
      step();
      check_val("rst_mid_oe_low", mem_oe, 0);
      n_ack = 0;
      repeat (8) begin
         step();
         if (cpu_ack) n_ack++;
      end
      check_val("rst_mid_no_ack", n_ack, 0);
      reset = 0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         if (cpu_ack) seen = 1;
      end
      cpu_req = 0;
      check_val("rst_mid_resumed", seen, 1);
      repeat (10) step();

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
